// File: rtl/scan_chain_sequencer.sv
// Boundary-scan chain sequencer.
// Each transaction has four phases:
//   1. Hold the chain still for SETTLE cycles so every cell takes a fresh
//      sample of its probe.
//   2. Shift a full 3*CELLS-bit word in, capturing the word shifted out.
//   3. Pulse o_done.
//   4. Return to IDLE.
// Drive permission is withheld while the chain holds half-shifted settings.
module scan_chain_sequencer #(
    parameter int CELLS  = 4,   // scan cells in the chain, at least 1
    parameter int SETTLE = 2    // non-shifting cycles before SHIFT, at least 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [3*CELLS-1:0]   i_wrData,
    input  logic                 i_driveEnable,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [3*CELLS-1:0]   o_rdData,
    output logic                 o_doShift,
    output logic                 o_canDrive,
    output logic                 o_shiftIn,
    input  logic                 i_shiftOut
);

    // Chain length and counter sizing; the counter only ever needs to
    // reach the larger of the two phase lengths, so it can never wrap.
    localparam int L    = 3 * CELLS;
    localparam int CMAX = (L > SETTLE) ? L : SETTLE;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [CW-1:0] SHIFT_LAST  = CW'(L - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [L-1:0]    sreg_q, sreg_d;
    logic [L-1:0]    rd_data_q, rd_data_d;

    // State register, phase counter, shift register and captured word.
    // All of these return to their idle values on reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Next-state logic.
    // sreg sends its MSB into the chain and takes the chain's far end into
    // its LSB. After L shifts, sreg therefore holds the chain word as it was
    // before shifting began, and the chain holds the loaded word.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        rd_data_d = rd_data_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    sreg_d  = i_wrData;
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == SETTLE_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_SHIFT: begin
                sreg_d = {sreg_q[L-2:0], i_shiftOut};
                if (cnt_q == SHIFT_LAST) begin
                    rd_data_d = {sreg_q[L-2:0], i_shiftOut};
                    cnt_d     = '0;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode.
    // Drive permission follows the host enable combinationally, but only
    // while the chain is stable (IDLE and SETTLE). This lets a driving cell
    // sample its own driven value during SETTLE.
    always_comb begin
        o_busy     = (state_q != ST_IDLE);
        o_done     = (state_q == ST_DONE);
        o_doShift  = (state_q == ST_SHIFT);
        o_canDrive = i_driveEnable &
                     ((state_q == ST_IDLE) || (state_q == ST_SETTLE));
        o_shiftIn  = sreg_q[L-1];
        o_rdData   = rd_data_q;
    end

endmodule

// File: tb/tb_scan_chain_sequencer.sv
// Self-checking bench for scan_chain_sequencer.
// Three instances are tested: (CELLS=2, SETTLE=2), (1, 2) and (4, 3).
// Each instance drives a small behavioural scan-chain model. In a
// non-shift cycle, each cell's input field samples its probe. The probe is
// the cell's own output field when the cell may drive and its tristate
// field is set; otherwise the probe is an external line value.
module tb_scan_chain_sequencer;

    logic clk;
    logic rst;

    logic        startA, deA, busyA, doneA, doShiftA, canDriveA, shiftInA, shiftOutA;
    logic [5:0]  wrA, rdA, chainA, preValA;
    logic [1:0]  extA;
    logic        preA;

    logic        startB, deB, busyB, doneB, doShiftB, canDriveB, shiftInB, shiftOutB;
    logic [2:0]  wrB, rdB, chainB, preValB;
    logic [0:0]  extB;
    logic        preB;

    logic        startC, deC, busyC, doneC, doShiftC, canDriveC, shiftInC, shiftOutC;
    logic [11:0] wrC, rdC, chainC, preValC;
    logic [3:0]  extC;
    logic        preC;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        doShift;
        logic        canDrive;
        logic        shiftIn;
        logic [11:0] rd;
        logic [11:0] chain;
    } obs_t;

    typedef struct {
        logic [5:0] wr;
        logic       de;
        logic [1:0] ext;
        logic [5:0] expRd;
    } vec_t;

    scan_chain_sequencer #(.CELLS(2), .SETTLE(2)) dutA (
        .i_clk(clk), .i_rst(rst), .i_start(startA), .i_wrData(wrA),
        .i_driveEnable(deA), .o_busy(busyA), .o_done(doneA), .o_rdData(rdA),
        .o_doShift(doShiftA), .o_canDrive(canDriveA), .o_shiftIn(shiftInA),
        .i_shiftOut(shiftOutA)
    );

    scan_chain_sequencer #(.CELLS(1), .SETTLE(2)) dutB (
        .i_clk(clk), .i_rst(rst), .i_start(startB), .i_wrData(wrB),
        .i_driveEnable(deB), .o_busy(busyB), .o_done(doneB), .o_rdData(rdB),
        .o_doShift(doShiftB), .o_canDrive(canDriveB), .o_shiftIn(shiftInB),
        .i_shiftOut(shiftOutB)
    );

    scan_chain_sequencer #(.CELLS(4), .SETTLE(3)) dutC (
        .i_clk(clk), .i_rst(rst), .i_start(startC), .i_wrData(wrC),
        .i_driveEnable(deC), .o_busy(busyC), .o_done(doneC), .o_rdData(rdC),
        .o_doShift(doShiftC), .o_canDrive(canDriveC), .o_shiftIn(shiftInC),
        .i_shiftOut(shiftOutC)
    );

    assign shiftOutA = chainA[5];
    assign shiftOutB = chainB[2];
    assign shiftOutC = chainC[11];

    // Free-running scan clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Chain model for instance A.
    always @(posedge clk) begin
        if (preA) chainA <= preValA;
        else if (doShiftA) chainA <= {chainA[4:0], shiftInA};
        else for (int c = 0; c < 2; c++)
            chainA[3*c] <= (canDriveA && chainA[3*c+1]) ? chainA[3*c+2] : extA[c];
    end

    // Chain model for instance B.
    always @(posedge clk) begin
        if (preB) chainB <= preValB;
        else if (doShiftB) chainB <= {chainB[1:0], shiftInB};
        else chainB[0] <= (canDriveB && chainB[1]) ? chainB[2] : extB[0];
    end

    // Chain model for instance C.
    always @(posedge clk) begin
        if (preC) chainC <= preValC;
        else if (doShiftC) chainC <= {chainC[10:0], shiftInC};
        else for (int c = 0; c < 4; c++)
            chainC[3*c] <= (canDriveC && chainC[3*c+1]) ? chainC[3*c+2] : extC[c];
    end

    function automatic int settleOf(input int sel);
        return (sel == 2) ? 3 : 2;
    endfunction

    function automatic int cellsOf(input int sel);
        return (sel == 0) ? 2 : ((sel == 1) ? 1 : 4);
    endfunction

    // Expected captured word: an unshifted chain whose input fields were
    // freshly sampled under the given drive enable and external lines.
    function automatic logic [11:0] predict(input logic [11:0] prev, input logic de,
                                            input logic [3:0] ext, input int cells);
        logic [11:0] r;
        r = prev;
        for (int c = 0; c < cells; c++)
            r[3*c] = (de && prev[3*c+1]) ? prev[3*c+2] : ext[c];
        return r;
    endfunction

    function automatic obs_t getOut(input int sel);
        obs_t o;
        o = '0;
        case (sel)
            0: begin
                o.busy = busyA; o.done = doneA; o.doShift = doShiftA;
                o.canDrive = canDriveA; o.shiftIn = shiftInA;
                o.rd = {6'b0, rdA}; o.chain = {6'b0, chainA};
            end
            1: begin
                o.busy = busyB; o.done = doneB; o.doShift = doShiftB;
                o.canDrive = canDriveB; o.shiftIn = shiftInB;
                o.rd = {9'b0, rdB}; o.chain = {9'b0, chainB};
            end
            default: begin
                o.busy = busyC; o.done = doneC; o.doShift = doShiftC;
                o.canDrive = canDriveC; o.shiftIn = shiftInC;
                o.rd = rdC; o.chain = chainC;
            end
        endcase
        return o;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int sel, input logic start, input logic [11:0] wr,
                                 input logic de, input logic [3:0] ext);
        case (sel)
            0: begin startA = start; wrA = wr[5:0]; deA = de; extA = ext[1:0]; end
            1: begin startB = start; wrB = wr[2:0]; deB = de; extB = ext[0:0]; end
            default: begin startC = start; wrC = wr; deC = de; extC = ext; end
        endcase
    endtask

    task automatic preload(input int sel, input logic [11:0] val);
        @(negedge clk);
        case (sel)
            0: begin preA = 1'b1; preValA = val[5:0]; end
            1: begin preB = 1'b1; preValB = val[2:0]; end
            default: begin preC = 1'b1; preValC = val; end
        endcase
        @(negedge clk);
        preA = 1'b0; preB = 1'b0; preC = 1'b0;
    endtask

    // One full transaction with per-cycle timing checks.
    // After the accepting edge, wrData is inverted, and drive enable is
    // toggled mid-SHIFT; neither change may have any effect. With poke set,
    // start is pulsed in SETTLE, SHIFT and DONE, and each pulse must be
    // ignored.
    task automatic runTxn(input int sel, input logic [11:0] wr, input logic de,
                          input logic [3:0] ext, input bit poke,
                          output logic [11:0] rd, output logic [11:0] chainDone);
        int s, l;
        obs_t o;
        logic [11:0] rdPrev;
        logic st, dcur;
        s = settleOf(sel);
        l = 3 * cellsOf(sel);
        rd = '0;
        chainDone = '0;
        @(negedge clk);
        o = getOut(sel);
        rdPrev = o.rd;
        checkOutput("idle before start", 32'(o.busy), 32'd0);
        applyStimulus(sel, 1'b1, wr, de, ext);
        for (int i = 1; i <= s + l + 1; i++) begin
            @(negedge clk);
            o = getOut(sel);
            checkOutput($sformatf("busy s%0d c%0d", sel, i), 32'(o.busy), 32'd1);
            checkOutput($sformatf("doShift s%0d c%0d", sel, i), 32'(o.doShift),
                        32'((i > s) && (i <= s + l)));
            checkOutput($sformatf("done s%0d c%0d", sel, i), 32'(o.done), 32'(i == s + l + 1));
            checkOutput($sformatf("canDrive s%0d c%0d", sel, i), 32'(o.canDrive),
                        32'((i <= s) ? de : 1'b0));
            if (i <= s + l)
                checkOutput($sformatf("rd stable s%0d c%0d", sel, i), 32'(o.rd), 32'(rdPrev));
            else begin
                rd = o.rd;
                chainDone = o.chain;
            end
            st   = poke && ((i == 1) || (i == s + 2) || (i == s + l + 1));
            dcur = ((i >= s + 1) && (i <= s + l - 1)) ? ~de : de;
            applyStimulus(sel, st, ~wr, dcur, ext);
        end
        @(negedge clk);
        o = getOut(sel);
        checkOutput($sformatf("idle after done s%0d", sel), 32'(o.busy), 32'd0);
        applyStimulus(sel, 1'b0, ~wr, de, ext);
        if (poke) begin
            repeat (2) begin
                @(negedge clk);
                o = getOut(sel);
                checkOutput($sformatf("no queued start s%0d", sel), 32'(o.busy), 32'd0);
            end
        end
    endtask

    // Main sequence: reset values, table on A, start handling, reset
    // mid-SHIFT, single-cell boundary, then random transactions on C.
    initial begin
        vec_t vecs[8];
        obs_t o;
        logic [11:0] rd, ch, prev, wr, expRd;
        logic de;
        logic [3:0] ext;

        vecs[0] = '{6'b000110, 1'b1, 2'b00, 6'b000000};
        vecs[1] = '{6'b000000, 1'b1, 2'b00, 6'b000111};
        vecs[2] = '{6'b111111, 1'b0, 2'b00, 6'b000000};
        vecs[3] = '{6'b000000, 1'b1, 2'b00, 6'b111111};
        vecs[4] = '{6'b101010, 1'b1, 2'b00, 6'b000000};
        vecs[5] = '{6'b000000, 1'b1, 2'b00, 6'b100010};
        vecs[6] = '{6'b011011, 1'b0, 2'b10, 6'b001000};
        vecs[7] = '{6'b000000, 1'b0, 2'b01, 6'b010011};

        rst = 1'b0;
        startA = 0; wrA = '0; deA = 1'b1; extA = '0; preA = 0; preValA = '0;
        startB = 0; wrB = '0; deB = 1'b0; extB = '0; preB = 0; preValB = '0;
        startC = 0; wrC = '0; deC = 1'b0; extC = '0; preC = 0; preValC = '0;
        #1 rst = 1'b1;
        #1;
        o = getOut(0);
        checkOutput("reset busy", 32'(o.busy), 32'd0);
        checkOutput("reset done", 32'(o.done), 32'd0);
        checkOutput("reset doShift", 32'(o.doShift), 32'd0);
        checkOutput("reset rdData", 32'(o.rd), 32'd0);
        checkOutput("reset shiftIn", 32'(o.shiftIn), 32'd0);
        checkOutput("reset canDrive de=1", 32'(o.canDrive), 32'd1);
        deA = 1'b0;
        #1;
        checkOutput("reset canDrive de=0", 32'(canDriveA), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        preload(0, 12'h000);
        for (int r = 0; r < 8; r++) begin
            runTxn(0, {6'b0, vecs[r].wr}, vecs[r].de, {2'b0, vecs[r].ext}, r == 2, rd, ch);
            checkOutput($sformatf("rdData row%0d", r), 32'(rd), 32'(vecs[r].expRd));
            checkOutput($sformatf("chain row%0d", r), 32'(ch), 32'(vecs[r].wr));
        end

        // Start held high: busy for 9 cycles, then exactly one idle cycle.
        @(negedge clk);
        startA = 1'b1;
        for (int j = 1; j <= 30; j++) begin
            @(negedge clk);
            checkOutput($sformatf("held start c%0d", j), 32'(busyA), 32'(((j - 1) % 10) < 9));
        end
        startA = 1'b0;

        // Asynchronous reset in the middle of SHIFT.
        @(negedge clk);
        applyStimulus(0, 1'b1, 12'h02d, 1'b1, 4'h0);
        @(negedge clk);
        startA = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mid shift before reset", 32'(doShiftA), 32'd1);
        #2 rst = 1'b1;
        #1;
        o = getOut(0);
        checkOutput("async reset busy", 32'(o.busy), 32'd0);
        checkOutput("async reset done", 32'(o.done), 32'd0);
        checkOutput("async reset doShift", 32'(o.doShift), 32'd0);
        checkOutput("async reset rdData", 32'(o.rd), 32'd0);
        checkOutput("async reset shiftIn", 32'(o.shiftIn), 32'd0);
        checkOutput("async reset canDrive", 32'(o.canDrive), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        runTxn(0, 12'h019, 1'b0, 4'h0, 1'b0, rd, ch);
        checkOutput("post reset chain", 32'(ch), 32'h19);

        // Single-cell boundary.
        preload(1, 12'b010);
        runTxn(1, 12'b101, 1'b1, 4'b0001, 1'b0, rd, ch);
        checkOutput("boundary rdData", 32'(rd), 32'b010);
        checkOutput("boundary chain", 32'(ch), 32'b101);

        // Random transactions on the four-cell instance.
        prev = 12'($urandom);
        preload(2, prev);
        for (int n = 0; n < 20; n++) begin
            wr  = 12'($urandom);
            de  = 1'($urandom_range(0, 1));
            ext = 4'($urandom_range(0, 15));
            expRd = predict(prev, de, ext, 4);
            runTxn(2, wr, de, ext, (n % 5) == 0, rd, ch);
            checkOutput($sformatf("random rdData n%0d", n), 32'(rd), 32'(expRd));
            checkOutput($sformatf("random chain n%0d", n), 32'(ch), 32'(wr));
            prev = wr;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
